// File: rtl/pps_conditioner.sv
// rtl/pps_conditioner.sv - GPS PPS deglitch, interval qualification and lock tracking
module pps_conditioner #(
    parameter int CW       = 28,
    parameter int NOMINAL  = 156250000,
    parameter int TOL      = 15625,
    parameter int MIN_HIGH = 16,
    parameter int LOCK_N   = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pps,
    input  logic          i_en,
    output logic          o_pps,
    output logic          o_pps_raw,
    output logic          o_valid,
    output logic [CW-1:0] o_period,
    output logic          o_early,
    output logic          o_missing
);

    localparam int FW = $clog2(MIN_HIGH + 1);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] LO_LIM = CW'(NOMINAL - TOL);
    localparam logic [CW-1:0] HI_LIM = CW'(NOMINAL + TOL);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic          sync1, sync2;
    logic [FW-1:0] hi_cnt;
    logic          evt;

    state_t        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [CW-1:0] ivl_q, ivl_d, ivl_inc;
    logic          pps_d, raw_d, early_d, missing_d, period_ld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_pps;
            sync2 <= sync1;
        end
    end

    // evt pulses once per high run, on the sample that completes MIN_HIGH highs
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            hi_cnt <= '0;
            evt    <= 1'b0;
        end else begin
            evt <= sync2 && (hi_cnt == FW'(MIN_HIGH - 1));
            if (!sync2) begin
                hi_cnt <= '0;
            end else if (hi_cnt != FW'(MIN_HIGH)) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    assign ivl_inc = (ivl_q == '1) ? ivl_q : ivl_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ivl_d     = ivl_inc;
        pps_d     = 1'b0;
        raw_d     = 1'b0;
        early_d   = 1'b0;
        missing_d = 1'b0;
        period_ld = 1'b0;

        if (!i_en) begin
            state_d = SEARCH;
            g_d     = '0;
            ivl_d   = '0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    g_d   = '0;
                    ivl_d = '0;
                    if (evt) begin
                        state_d = ACQUIRE;
                        ivl_d   = CW'(1);
                        raw_d   = 1'b1;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (evt) begin
                        raw_d     = 1'b1;
                        period_ld = 1'b1;
                        ivl_d     = CW'(1);
                        if (ivl_q < LO_LIM) begin
                            early_d = 1'b1;
                            g_d     = '0;
                            state_d = ACQUIRE;
                        end else if (ivl_q <= HI_LIM) begin
                            if (state_q == LOCKED) begin
                                pps_d = 1'b1;
                            end else begin
                                g_d = g_q + 1'b1;
                                if (g_d == GW'(LOCK_N)) begin
                                    state_d = LOCKED;
                                    pps_d   = 1'b1;
                                end
                            end
                        end else begin
                            g_d     = '0;
                            state_d = ACQUIRE;
                        end
                    end else if (ivl_q == HI_LIM) begin
                        // counter is about to pass the window: an interval of HI_LIM+1 never happens
                        missing_d = 1'b1;
                        state_d   = SEARCH;
                        g_d       = '0;
                        ivl_d     = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    g_d     = '0;
                    ivl_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= SEARCH;
            g_q       <= '0;
            ivl_q     <= '0;
            o_pps     <= 1'b0;
            o_pps_raw <= 1'b0;
            o_early   <= 1'b0;
            o_missing <= 1'b0;
            o_period  <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ivl_q     <= ivl_d;
            o_pps     <= pps_d;
            o_pps_raw <= raw_d;
            o_early   <= early_d;
            o_missing <= missing_d;
            if (period_ld) begin
                o_period <= ivl_q;
            end
        end
    end

    assign o_valid = (state_q == LOCKED);

endmodule

// File: tb/tb_pps_conditioner.sv
// tb/tb_pps_conditioner.sv - randomized PPS schedule checked against an interval-level model
module tb_pps_conditioner;

    localparam int CW       = 16;
    localparam int NOMINAL  = 100;
    localparam int TOL      = 2;
    localparam int MIN_HIGH = 4;
    localparam int LOCK_N   = 3;
    localparam int N        = 8000;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_pps = 1'b0;
    logic          i_en  = 1'b1;
    logic          o_pps, o_pps_raw, o_valid, o_early, o_missing;
    logic [CW-1:0] o_period;

    pps_conditioner #(
        .CW(CW), .NOMINAL(NOMINAL), .TOL(TOL), .MIN_HIGH(MIN_HIGH), .LOCK_N(LOCK_N)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pps(i_pps), .i_en(i_en),
        .o_pps(o_pps), .o_pps_raw(o_pps_raw), .o_valid(o_valid),
        .o_period(o_period), .o_early(o_early), .o_missing(o_missing)
    );

    always #5 i_clk = ~i_clk;

    bit          pps_a [0:N-1];
    bit          rst_a [0:N-1];
    bit          en_a  [0:N-1];
    logic [20:0] exp_a [0:N-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_pulse(input int t, input int len);
        for (int i = 0; i < len; i++) if (t + i < N) pps_a[t + i] = 1'b1;
    endtask

    // 0 none, 1 short glitch, 2 reset mid-interval, 3 enable low mid-interval
    task automatic add_action(input int cur, input int act);
        case (act)
            1: add_pulse(cur + 30 + $urandom_range(0, 30), $urandom_range(1, MIN_HIGH - 1));
            2: for (int i = 0; i <= $urandom_range(0, 1); i++) if (cur + 50 + i < N) rst_a[cur + 50 + i] = 1'b1;
            3: for (int i = 40; i < 50; i++) if (cur + i < N) en_a[cur + i] = 1'b0;
            default: ;
        endcase
    endtask

    // A pulse whose first sampled-high edge is t is recognised at edge t+MIN_HIGH+2
    function automatic bit event_at(input int n);
        if (n < MIN_HIGH + 3) return 1'b0;
        if (pps_a[n - MIN_HIGH - 3]) return 1'b0;
        for (int k = n - MIN_HIGH - 2; k <= n - 3; k++) if (!pps_a[k]) return 1'b0;
        for (int k = n - MIN_HIGH - 3; k <= n; k++) if (rst_a[k] || !en_a[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_model();
        int st = 0;
        int g = 0;
        int last = 0;
        int period = 0;
        int el;
        bit ev, p, r, e, m;
        for (int n = 0; n < N; n++) begin
            p = 0; r = 0; e = 0; m = 0;
            ev = event_at(n);
            if (rst_a[n]) begin
                st = 0; g = 0; period = 0;
            end else if (!en_a[n]) begin
                st = 0; g = 0;
            end else if (st == 0) begin
                if (ev) begin
                    r = 1; st = 1; g = 0; last = n;
                end
            end else begin
                el = n - last;
                if (ev) begin
                    r = 1; period = el; last = n;
                    if (el < NOMINAL - TOL) begin
                        e = 1; g = 0; st = 1;
                    end else if (el <= NOMINAL + TOL) begin
                        if (st == 2) p = 1;
                        else begin
                            g++;
                            if (g == LOCK_N) begin st = 2; p = 1; end
                        end
                    end else begin
                        g = 0; st = 1;
                    end
                end else if (el == NOMINAL + TOL) begin
                    m = 1; st = 0; g = 0;
                end
            end
            exp_a[n] = {p, r, (st == 2), e, m, CW'(period)};
        end
    endtask

    int dir_gap [25] = '{100, 100, 100, 100, 100, 97, 100, 100, 100, 102, 98, 150, 100,
                         100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    int dir_act [25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 2, 0, 0, 0, 0, 3, 0, 0, 0};

    initial begin
        int cur, r, gap, act, exp_pps, got_pps;
        for (int n = 0; n < N; n++) begin
            pps_a[n] = 1'b0; rst_a[n] = (n < 4); en_a[n] = 1'b1;
        end
        cur = 10;
        for (int i = 0; i < 25; i++) begin
            add_pulse(cur, 10);
            add_action(cur, dir_act[i]);
            cur += dir_gap[i];
        end
        while (cur < N - 300) begin
            r = $urandom_range(0, 19);
            act = 0;
            if (r < 12)      gap = $urandom_range(98, 102);
            else if (r < 14) gap = $urandom_range(90, 97);
            else if (r < 16) gap = $urandom_range(103, 200);
            else begin
                gap = $urandom_range(98, 102);
                act = (r == 19) ? 0 : r - 15;
            end
            add_pulse(cur, $urandom_range(MIN_HIGH, 12));
            add_action(cur, act);
            cur += gap;
        end
        build_model();

        exp_pps = 0;
        got_pps = 0;
        for (int n = 0; n < N; n++) begin
            i_pps = pps_a[n];
            i_rst = rst_a[n];
            i_en  = en_a[n];
            @(posedge i_clk);
            @(negedge i_clk);
            check($sformatf("cyc%0d {pps,raw,valid,early,missing,period}", n),
                  {o_pps, o_pps_raw, o_valid, o_early, o_missing, o_period}, exp_a[n]);
            if (o_pps) got_pps++;
            if (exp_a[n][20]) exp_pps++;
        end
        check("qualified pps count", got_pps, exp_pps);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pps_conditioner.md
PPS_CONDITIONER -- requirements
Module: pps_conditioner

Interface
REQ-001 SHALL have parameter CW, default 28: width of interval counter and o_period.
REQ-002 SHALL have parameter NOMINAL, default 156250000: expected i_clk cycles per PPS interval.
REQ-003 SHALL have parameter TOL, default 15625: allowed interval deviation in cycles (+/-).
REQ-004 SHALL have parameter MIN_HIGH, default 16: consecutive high samples required to accept an edge.
REQ-005 SHALL have parameter LOCK_N, default 3: consecutive good intervals required to lock.
REQ-006 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_pps  input  1  raw asynchronous PPS from GPS receiver.
REQ-009 SHALL have port i_en  input  1  enable; low forces SEARCH and suppresses all pulses.
REQ-010 SHALL have port o_pps  output  1  one-cycle qualified PPS strobe, fed to gpsclock i_pps.
REQ-011 SHALL have port o_pps_raw  output  1  one-cycle strobe per filtered edge, unqualified.
REQ-012 SHALL have port o_valid  output  1  high while state is LOCKED.
REQ-013 SHALL have port o_period  output  CW  cycle count of last completed interval.
REQ-014 SHALL have port o_early  output  1  one-cycle flag: interval < NOMINAL-TOL.
REQ-015 SHALL have port o_missing  output  1  one-cycle flag: no edge by NOMINAL+TOL.

Function
REQ-016 SHALL pass i_pps through a two-flop synchronizer before any other use.
REQ-017 SHALL count consecutive synchronized-high cycles; count clears on any low sample and raises event E exactly once, when it reaches MIN_HIGH.
REQ-018 SHALL assert o_pps_raw MIN_HIGH+2 cycles after the first i_clk edge sampling i_pps high; pulses shorter than MIN_HIGH cycles produce no event.
REQ-019 SHALL run an interval counter that loads 1 on the cycle after E and increments every cycle, saturating at 2^CW-1; interval = counter value at E.
REQ-020 SHALL load o_period with the interval on each E except the first E after SEARCH.
REQ-021 SHALL classify an interval good when NOMINAL-TOL <= interval <= NOMINAL+TOL.
REQ-022 SHALL implement FSM SEARCH, ACQUIRE, LOCKED with a good-interval counter G.
REQ-023 SEARCH: on E go ACQUIRE, G=0, start interval counter; no o_pps.
REQ-024 ACQUIRE: good E increments G; when G reaches LOCK_N go LOCKED and assert o_pps on that E.
REQ-025 ACQUIRE: early E asserts o_early, G=0, stay ACQUIRE, restart interval.
REQ-026 LOCKED: good E asserts o_pps in the same cycle as o_pps_raw.
REQ-027 LOCKED: early E asserts o_early, suppresses o_pps, goes ACQUIRE with G=0.
REQ-028 ACQUIRE or LOCKED: counter reaching NOMINAL+TOL+1 without E asserts o_missing for one cycle, goes SEARCH, G=0.
REQ-029 SHALL give E precedence over timeout when both occur in the same cycle; interval exactly NOMINAL+TOL is good.
REQ-030 SHALL never assert o_pps unless o_valid is high in the same or next cycle.
REQ-031 With i_en low: FSM held in SEARCH, G=0, counters clear, o_pps/o_pps_raw/o_early/o_missing low; o_period holds.

Reset
REQ-032 On i_rst high at a clock edge: synchronizer flops, filter, interval counter, G and o_period cleared to 0; FSM to SEARCH.
REQ-033 During and after reset, all outputs 0 until new qualified activity; reset mid-interval discards the interval.

Verification (NOMINAL=100, TOL=2, MIN_HIGH=4, LOCK_N=3, pulses 10 cycles high)
REQ-034 Edges every 100 cycles -> o_pps_raw each edge; o_valid and first o_pps at 4th edge; o_period=100.
REQ-035 Locked, one edge at interval 97 -> o_early, no o_pps, o_valid drops; relocks after 3 further good intervals.
REQ-036 Locked, edge withheld -> o_missing at counter=103, FSM SEARCH, o_valid=0; o_period holds 100.
REQ-037 3-cycle-high glitch mid-interval -> no o_pps_raw, lock and o_period unaffected.
REQ-038 Intervals 102 then 98 -> both good; interval 103 edge impossible (timeout at 103 precedes).
REQ-039 i_rst asserted 50 cycles into locked interval -> all outputs 0 next cycle; reacquire needs 4 edges.
